// File: rtl/tx_arb_pkg.sv
// tx_frame_arbiter shared types and constants.
// FSM state encoding and field widths.
package tx_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    SENDING,
    GAP
  } state_t;

  localparam int AUX_W       = 8;
  localparam int SEG_W       = 16;
  localparam int TXID_W      = 8;
  localparam int IFG_DEFAULT = 12;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches from ptr+1 upward, wrapping at N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          any
);

  // First pending source after the last winner
  always_comb begin
    int j;
    j       = 0;
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any     = 1'b1;
        win[j]  = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Round-robin sharing of the TX frame generator.
// Optional busy watchdog: define TX_ARB_TIMEOUT_EN.
module tx_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int IFG_CYCLES   = IFG_DEFAULT,
  parameter int BUSY_TIMEOUT = 1000
) (
  input  logic                      clk125MHz,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [AUX_W*N_REQ-1:0]    req_aux,
  input  logic [SEG_W*N_REQ-1:0]    req_segment_num,
  input  logic [TXID_W*N_REQ-1:0]   req_txid,
  input  logic                      busy,
  output logic                      start_sending,
  output logic [AUX_W-1:0]          aux,
  output logic [SEG_W-1:0]          segment_num,
  output logic [TXID_W-1:0]         txid,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic                      timeout_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW =
    (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic [CW-1:0] GAP_LAST =
    CW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam state_t AFTER =
    (IFG_CYCLES == 0) ? IDLE : GAP;
  localparam logic [IW-1:0] PTR_RST = IW'(N_REQ - 1);

  if (N_REQ < 2 || N_REQ > 8 ||
      BUSY_TIMEOUT < 1 || BUSY_TIMEOUT > 65535) begin : g_bad
    $error("tx_frame_arbiter: parameter out of range");
  end

  state_t          state, nxt;
  logic [IW-1:0]   ptr;
  logic [N_REQ-1:0] win;
  logic [IW-1:0]   win_idx;
  logic            any;
  logic [CW-1:0]   gcnt;
  logic            load;
  logic            fin;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  assign start_sending = (state == START);

`ifdef TX_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(BUSY_TIMEOUT - 1);
  logic [15:0] wdog;
  logic        to_hit;
  logic        to_q;

  // Watchdog runs only while waiting for busy
  always_ff @(posedge clk125MHz or posedge rst) begin
    if (rst) begin
      wdog <= '0;
      to_q <= 1'b0;
    end else begin
      wdog <= (state == WAIT_BUSY) ? wdog + 1'b1 : '0;
      to_q <= to_hit;
    end
  end

  assign timeout_err = to_q;
`else
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk125MHz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state and per-cycle strobes
  always_comb begin
    nxt  = state;
    load = 1'b0;
    fin  = 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
    to_hit = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!busy && any) begin
          load = 1'b1;
          nxt  = START;
        end
      end
      START: nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy) begin
          nxt = SENDING;
`ifdef TX_ARB_TIMEOUT_EN
        end else if (wdog == WD_LAST) begin
          fin    = 1'b1;
          to_hit = 1'b1;
          nxt    = AFTER;
`endif
        end
      end
      SENDING: begin
        if (!busy) begin
          fin = 1'b1;
          nxt = AFTER;
        end
      end
      GAP: begin
        if (gcnt == GAP_LAST) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Grant, pointer, latched fields, done, gap count
  always_ff @(posedge clk125MHz or posedge rst) begin
    if (rst) begin
      ptr         <= PTR_RST;
      grant       <= '0;
      done        <= '0;
      aux         <= '0;
      segment_num <= '0;
      txid        <= '0;
      gcnt        <= '0;
    end else begin
      done <= '0;
      gcnt <= (state == GAP) ? gcnt + 1'b1 : '0;
      if (load) begin
        grant       <= win;
        ptr         <= win_idx;
        aux         <= req_aux[win_idx*AUX_W +: AUX_W];
        segment_num <= req_segment_num[win_idx*SEG_W +: SEG_W];
        txid        <= req_txid[win_idx*TXID_W +: TXID_W];
      end
      if (fin) begin
        done  <= grant;
        grant <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter (N_REQ=2).
// Table of frames plus hand-written corner sequences.
module tb_tx_frame_arbiter;

  logic        clk125MHz = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [15:0] req_aux = '0;
  logic [31:0] req_segment_num = '0;
  logic [15:0] req_txid = '0;
  logic        busy = 1'b0;
  logic        start_sending;
  logic [7:0]  aux;
  logic [15:0] segment_num;
  logic [7:0]  txid;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic        timeout_err;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  tx_frame_arbiter #(
    .N_REQ(2), .IFG_CYCLES(12), .BUSY_TIMEOUT(20)
  ) dut (
    .clk125MHz       (clk125MHz),
    .rst             (rst),
    .req             (req),
    .req_aux         (req_aux),
    .req_segment_num (req_segment_num),
    .req_txid        (req_txid),
    .busy            (busy),
    .start_sending   (start_sending),
    .aux             (aux),
    .segment_num     (segment_num),
    .txid            (txid),
    .grant           (grant),
    .done            (done),
    .timeout_err     (timeout_err)
  );

  always #4 clk125MHz = ~clk125MHz;
  always @(posedge clk125MHz) cyc++;

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  aux0, aux1;
    logic [15:0] seg0, seg1;
    logic [7:0]  tx0, tx1;
    logic [1:0]  g;
    logic [7:0]  eaux;
    logic [15:0] eseg;
    logic [7:0]  etx;
  } vec_t;

  vec_t tv[7];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk125MHz);
    #1;
  endtask

  task automatic wait_start(input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (start_sending) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("start_wait_bound", 0, 1);
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {start_sending, aux, segment_num, txid,
                 grant, done, timeout_err}, 0);
  endtask

  int last_start;
  int now_start;
  logic ok;

  initial begin
    tv[0] = '{2'b01, 8'hA5, 8'h11, 16'h0003, 16'h1111,
              8'h01, 8'h22, 2'b01, 8'hA5, 16'h0003, 8'h01};
    tv[1] = '{2'b10, 8'hB0, 8'hC3, 16'h00B0, 16'h1234,
              8'hB1, 8'h5E, 2'b10, 8'hC3, 16'h1234, 8'h5E};
    tv[2] = '{2'b11, 8'h0F, 8'h70, 16'h0F0F, 16'h7007,
              8'hF0, 8'h07, 2'b01, 8'h0F, 16'h0F0F, 8'hF0};
    tv[3] = '{2'b11, 8'h0F, 8'h70, 16'h0F0F, 16'h7007,
              8'hF0, 8'h07, 2'b10, 8'h70, 16'h7007, 8'h07};
    tv[4] = '{2'b11, 8'hAA, 8'hBB, 16'hAAAA, 16'hBBBB,
              8'h55, 8'h66, 2'b01, 8'hAA, 16'hAAAA, 8'h55};
    tv[5] = '{2'b10, 8'h00, 8'hFF, 16'h0000, 16'hFFFF,
              8'h00, 8'hFF, 2'b10, 8'hFF, 16'hFFFF, 8'hFF};
    tv[6] = '{2'b01, 8'h81, 8'h00, 16'h8001, 16'h0000,
              8'h18, 8'h00, 2'b01, 8'h81, 16'h8001, 8'h18};

    #1;
    check_idle_outputs("reset_outputs");
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("post_reset_idle");

    last_start = 0;
    for (int i = 0; i < 7; i++) begin
      req             = tv[i].req;
      req_aux         = {tv[i].aux1, tv[i].aux0};
      req_segment_num = {tv[i].seg1, tv[i].seg0};
      req_txid        = {tv[i].tx1, tv[i].tx0};
      wait_start(40, ok);
      if (!ok) break;
      now_start = cyc;
      if (i > 0)
        check($sformatf("start_spacing_%0d", i),
              32'(now_start - last_start >= 17), 1);
      last_start = now_start;
      check($sformatf("grant_%0d", i), grant, tv[i].g);
      check($sformatf("aux_%0d", i), aux, tv[i].eaux);
      check($sformatf("seg_%0d", i), segment_num, tv[i].eseg);
      check($sformatf("txid_%0d", i), txid, tv[i].etx);
      req_aux         = ~req_aux;
      req_segment_num = ~req_segment_num;
      req_txid        = ~req_txid;
      tick();
      check($sformatf("start_pulse_%0d", i), start_sending, 0);
      tick();
      busy = 1'b1;
      repeat (3) tick();
      busy = 1'b0;
      check($sformatf("no_early_done_%0d", i), done, 0);
      tick();
      check($sformatf("done_%0d", i), done, tv[i].g);
      check($sformatf("grant_clr_%0d", i), grant, 0);
      check($sformatf("aux_hold_%0d", i), aux, tv[i].eaux);
      check($sformatf("seg_hold_%0d", i), segment_num,
            tv[i].eseg);
      tick();
      check($sformatf("done_pulse_%0d", i), done, 0);
      req = req & ~tv[i].g;
    end

    req = '0;
    repeat (16) tick();

    // generator busy elsewhere: hold off, one-cycle busy frame
    busy = 1'b1;
    req  = 2'b10;
    req_aux = 16'h3C00;
    ok = 1'b0;
    repeat (6) begin
      tick();
      if (start_sending || grant != 0) ok = 1'b1;
    end
    check("ext_busy_holdoff", ok, 0);
    busy = 1'b0;
    tick();
    check("ext_busy_start", start_sending, 1);
    check("ext_busy_grant", grant, 2'b10);
    check("ext_busy_aux", aux, 8'h3C);
    req = '0;
    tick();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    check("short_busy_done", done, 2'b10);
    repeat (16) tick();

    // reset during SENDING, then fresh arbitration
    req = 2'b11;
    req_aux = 16'h2211;
    wait_start(40, ok);
    tick();
    busy = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_frame_reset");
    busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    wait_start(5, ok);
    check("post_reset_grant", grant, 2'b01);
    check("post_reset_aux", aux, 8'h11);
    tick();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    check("post_reset_done", done, 2'b01);
    req = 2'b00;
    repeat (16) tick();

`ifdef TX_ARB_TIMEOUT_EN
    req = 2'b10;
    wait_start(40, ok);
    req = 2'b00;
    ok = 1'b0;
    repeat (20) begin
      tick();
      if (done != 0 || timeout_err) ok = 1'b1;
    end
    check("wd_no_early", ok, 0);
    tick();
    check("wd_done", done, 2'b10);
    check("wd_err", timeout_err, 1);
    tick();
    check("wd_err_pulse", timeout_err, 0);
`else
    req = 2'b10;
    wait_start(40, ok);
    req = 2'b00;
    repeat (30) tick();
    check("no_wd_grant_held", grant, 2'b10);
    check("no_wd_err", timeout_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
